// File: rtl/uart_cmd_controller.sv
// Byte-level command controller: parses A/B operand frames from the UART, drives the multiplier, returns the product.
// Optional checksum byte on request and response frames when UART_CMD_CHECKSUM_EN is defined.
module uart_cmd_controller #(
  parameter int unsigned OP_WIDTH       = 16,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter logic [7:0]  RESP_BYTE      = 8'h5A,
  parameter logic [7:0]  ERR_BYTE       = 8'hEE,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [7:0]            tx_data,
  output logic                  tx_start,
  input  logic                  tx_ready,
  output logic [OP_WIDTH-1:0]   op_a,
  output logic [OP_WIDTH-1:0]   op_b,
  output logic                  op_valid,
  input  logic [2*OP_WIDTH-1:0] result,
  input  logic                  result_valid,
  output logic                  busy,
  output logic                  frame_error
);

  localparam int unsigned NB    = OP_WIDTH / 8;
  localparam int unsigned RES_W = 2 * OP_WIDTH;
`ifdef UART_CMD_CHECKSUM_EN
  localparam int unsigned TX_BYTES = 2 * NB + 1;
  localparam int unsigned SR_W     = RES_W + 8;
`else
  localparam int unsigned TX_BYTES = 2 * NB;
  localparam int unsigned SR_W     = RES_W;
`endif
  localparam int unsigned BCW = $clog2(NB + 1);
  localparam int unsigned TCW = $clog2(TX_BYTES + 1);
  localparam int unsigned CW  = $clog2(TIMEOUT_CYCLES);

  localparam logic [BCW-1:0] NB_LAST = BCW'(NB - 1);
  localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [TCW-1:0] TX_LEN  = TCW'(TX_BYTES);

  typedef enum logic [2:0] {
    S_IDLE, S_RX_A, S_RX_B, S_RX_CK, S_EXEC, S_TX_HDR, S_TX_GAP, S_TX_DATA
  } state_e;

  state_e              state_q, state_d;
  logic [BCW-1:0]      byte_cnt_q, byte_cnt_d;
  logic [CW-1:0]       timeout_cnt_q, timeout_cnt_d;
  logic [TCW-1:0]      tx_cnt_q, tx_cnt_d;
  logic [OP_WIDTH-1:0] shadow_a_q, shadow_a_d;
  logic [OP_WIDTH-1:0] shadow_b_q, shadow_b_d;
  logic [OP_WIDTH-1:0] op_a_q, op_a_d;
  logic [OP_WIDTH-1:0] op_b_q, op_b_d;
  logic                op_valid_q, op_valid_d;
  logic [SR_W-1:0]     sr_q, sr_d;
  logic                gap_q, gap_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic                frame_error_q, frame_error_d;
`ifdef UART_CMD_CHECKSUM_EN
  logic [7:0]          ck_q, ck_d;

  function automatic logic [7:0] xor_bytes(input logic [RES_W-1:0] v);
    logic [7:0] x;
    x = '0;
    for (int unsigned i = 0; i < 2 * NB; i++) x ^= v[8*i +: 8];
    return x;
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      byte_cnt_q    <= '0;
      timeout_cnt_q <= '0;
      tx_cnt_q      <= '0;
      shadow_a_q    <= '0;
      shadow_b_q    <= '0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      op_valid_q    <= 1'b0;
      sr_q          <= '0;
      gap_q         <= 1'b0;
      err_q         <= 1'b0;
      busy_q        <= 1'b0;
      frame_error_q <= 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
      ck_q          <= '0;
`endif
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
      tx_cnt_q      <= tx_cnt_d;
      shadow_a_q    <= shadow_a_d;
      shadow_b_q    <= shadow_b_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      op_valid_q    <= op_valid_d;
      sr_q          <= sr_d;
      gap_q         <= gap_d;
      err_q         <= err_d;
      busy_q        <= busy_d;
      frame_error_q <= frame_error_d;
`ifdef UART_CMD_CHECKSUM_EN
      ck_q          <= ck_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    timeout_cnt_d = timeout_cnt_q;
    tx_cnt_d      = tx_cnt_q;
    shadow_a_d    = shadow_a_q;
    shadow_b_d    = shadow_b_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    op_valid_d    = 1'b0;
    sr_d          = sr_q;
    gap_d         = gap_q;
    err_d         = err_q;
    frame_error_d = 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
    ck_d          = ck_q;
`endif

    case (state_q)
      S_IDLE: begin
        byte_cnt_d    = '0;
        timeout_cnt_d = '0;
        if (rx_valid && rx_data == SYNC_BYTE) begin
          state_d = S_RX_A;
`ifdef UART_CMD_CHECKSUM_EN
          ck_d    = '0;
`endif
        end
      end

      S_RX_A, S_RX_B, S_RX_CK: begin
        // An arriving byte always beats the timeout terminal count.
        if (rx_valid) begin
          timeout_cnt_d = '0;
`ifdef UART_CMD_CHECKSUM_EN
          ck_d = ck_q ^ rx_data;
`endif
          if (state_q == S_RX_A) begin
            shadow_a_d = (shadow_a_q << 8) | OP_WIDTH'(rx_data);
            if (byte_cnt_q == NB_LAST) begin
              byte_cnt_d = '0;
              state_d    = S_RX_B;
            end else begin
              byte_cnt_d = byte_cnt_q + BCW'(1);
            end
          end else if (state_q == S_RX_B) begin
            shadow_b_d = (shadow_b_q << 8) | OP_WIDTH'(rx_data);
            if (byte_cnt_q == NB_LAST) begin
              byte_cnt_d = '0;
`ifdef UART_CMD_CHECKSUM_EN
              state_d    = S_RX_CK;
`else
              state_d    = S_EXEC;
              op_a_d     = shadow_a_q;
              op_b_d     = shadow_b_d;
              op_valid_d = 1'b1;
`endif
            end else begin
              byte_cnt_d = byte_cnt_q + BCW'(1);
            end
          end else begin
`ifdef UART_CMD_CHECKSUM_EN
            if (rx_data == ck_q) begin
              state_d    = S_EXEC;
              op_a_d     = shadow_a_q;
              op_b_d     = shadow_b_q;
              op_valid_d = 1'b1;
            end else begin
              frame_error_d = 1'b1;
              err_d         = 1'b1;
              tx_cnt_d      = '0;
              state_d       = S_TX_HDR;
            end
`else
            state_d = S_IDLE;
`endif
          end
        end else if (timeout_cnt_q == TO_LAST) begin
          frame_error_d = 1'b1;
          timeout_cnt_d = '0;
          byte_cnt_d    = '0;
          state_d       = S_IDLE;
        end else begin
          timeout_cnt_d = timeout_cnt_q + CW'(1);
        end
      end

      S_EXEC: begin
        if (result_valid) begin
`ifdef UART_CMD_CHECKSUM_EN
          sr_d = {result, xor_bytes(result)};
`else
          sr_d = result;
`endif
          tx_cnt_d = TX_LEN;
          err_d    = 1'b0;
          state_d  = S_TX_HDR;
        end
      end

      S_TX_HDR: begin
        if (tx_ready) begin
          gap_d   = 1'b1;
          state_d = S_TX_GAP;
        end
      end

      S_TX_GAP: begin
        // First gap cycle is unconditional: the transmitter only drops ready one cycle after start.
        if (gap_q) begin
          gap_d = 1'b0;
        end else if (tx_ready) begin
          if (tx_cnt_q != '0) begin
            state_d = S_TX_DATA;
          end else begin
            err_d   = 1'b0;
            state_d = S_IDLE;
          end
        end
      end

      S_TX_DATA: begin
        if (tx_ready) begin
          sr_d     = sr_q << 8;
          tx_cnt_d = tx_cnt_q - TCW'(1);
          gap_d    = 1'b1;
          state_d  = S_TX_GAP;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_comb begin
    tx_start = 1'b0;
    tx_data  = '0;
    if (!reset && tx_ready && (state_q == S_TX_HDR || state_q == S_TX_DATA)) begin
      tx_start = 1'b1;
      if (state_q == S_TX_HDR) tx_data = err_q ? ERR_BYTE : RESP_BYTE;
      else                     tx_data = sr_q[SR_W-1 -: 8];
    end
  end

  assign op_a        = op_a_q;
  assign op_b        = op_b_q;
  assign op_valid    = op_valid_q;
  assign busy        = busy_q;
  assign frame_error = frame_error_q;

endmodule

// File: tb/tb_uart_cmd_controller.sv
// Directed self-checking bench for uart_cmd_controller with a simple transmitter model.
// Also covers the UART_CMD_CHECKSUM_EN build when that macro is defined.
module tb_uart_cmd_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_ready;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        op_valid;
  logic [31:0] result;
  logic        result_valid;
  logic        busy;
  logic        frame_error;

  int checks   = 0;
  int failures = 0;

  logic [7:0] tx_q[$];
  int         tx_viol  = 0;
  int         opv_cnt  = 0;
  int         opv_long = 0;
  int         fe_cnt   = 0;
  logic       prev_start = 1'b0;
  logic       prev_opv   = 1'b0;
  logic       hold_ready = 1'b0;

  uart_cmd_controller #(
    .OP_WIDTH      (16),
    .SYNC_BYTE     (8'hA5),
    .RESP_BYTE     (8'h5A),
    .ERR_BYTE      (8'hEE),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_ready    (tx_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .op_valid    (op_valid),
    .result      (result),
    .result_valid(result_valid),
    .busy        (busy),
    .frame_error (frame_error)
  );

  always #5 clk = ~clk;

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (tx_start) begin
      tx_q.push_back(tx_data);
      if (!tx_ready) tx_viol++;
      if (prev_start) tx_viol++;
    end
    if (op_valid) opv_cnt++;
    if (op_valid && prev_opv) opv_long++;
    if (frame_error) fe_cnt++;
    prev_start = tx_start;
    prev_opv   = op_valid;
  end

  // Transmitter model: ready drops the cycle after a start and stays low for a few cycles.
  initial begin
    int   busy_cnt;
    logic start_now;
    busy_cnt = 0;
    tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      start_now = tx_start;
      @(posedge clk);
      #1;
      if (start_now) busy_cnt = 4;
      else if (busy_cnt > 0) busy_cnt--;
      tx_ready = (busy_cnt == 0) && !hold_ready && !start_now;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data  = '0;
  endtask

  task automatic send_frame(input logic [15:0] a, input logic [15:0] b);
    send_byte(8'hA5);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    send_byte(b[15:8]);
    send_byte(b[7:0]);
`ifdef UART_CMD_CHECKSUM_EN
    send_byte(a[15:8] ^ a[7:0] ^ b[15:8] ^ b[7:0]);
`endif
  endtask

  task automatic give_result(input string tag, input logic [31:0] r);
    int n;
    n = 0;
    while (!op_valid && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_opv_seen"}, 64'(op_valid), 64'(1));
    tick();
    result       = r;
    result_valid = 1'b1;
    tick();
    result_valid = 1'b0;
  endtask

  task automatic expect_resp(input string tag, input int base, input logic [31:0] r);
    logic [7:0] exp[$];
    int         n;
    logic [7:0] got;
    exp.push_back(8'h5A);
    exp.push_back(r[31:24]);
    exp.push_back(r[23:16]);
    exp.push_back(r[15:8]);
    exp.push_back(r[7:0]);
`ifdef UART_CMD_CHECKSUM_EN
    exp.push_back(r[31:24] ^ r[23:16] ^ r[15:8] ^ r[7:0]);
`endif
    n = 0;
    while (!(tx_q.size() >= base + exp.size() && !busy) && n < 1000) begin
      tick();
      n++;
    end
    chk({tag, "_tx_count"}, 64'(tx_q.size() - base), 64'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      got = (base + i < tx_q.size()) ? tx_q[base + i] : 8'hxx;
      chk($sformatf("%s_tx_byte%0d", tag, i), 64'(got), 64'(exp[i]));
    end
    chk({tag, "_busy_low"}, 64'(busy), 64'(0));
  endtask

  initial begin
    int base;
    int opv0;
    int fe0;
    int n;

    reset        = 1'b1;
    rx_data      = '0;
    rx_valid     = 1'b0;
    result       = '0;
    result_valid = 1'b0;
    repeat (3) tick();
    chk("rst_tx_data", 64'(tx_data), 64'(0));
    chk("rst_tx_start", 64'(tx_start), 64'(0));
    chk("rst_op_a", 64'(op_a), 64'(0));
    chk("rst_op_b", 64'(op_b), 64'(0));
    chk("rst_op_valid", 64'(op_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_frame_error", 64'(frame_error), 64'(0));
    reset = 1'b0;
    tick();

    // Basic frame
    base = tx_q.size();
    opv0 = opv_cnt;
    send_frame(16'h0003, 16'h0004);
    give_result("basic", 32'h0000000C);
    expect_resp("basic", base, 32'h0000000C);
    chk("basic_op_a", 64'(op_a), 64'h0003);
    chk("basic_op_b", 64'(op_b), 64'h0004);
    chk("basic_opv_pulses", 64'(opv_cnt - opv0), 64'(1));
    chk("basic_opv_long", 64'(opv_long), 64'(0));

    // Noise before sync; stray result_valid in IDLE must be ignored
    result       = 32'hDEADBEEF;
    result_valid = 1'b1;
    tick();
    result_valid = 1'b0;
    send_byte(8'h11);
    send_byte(8'h22);
    chk("noise_busy", 64'(busy), 64'(0));
    base = tx_q.size();
    send_frame(16'h1234, 16'h5678);
    give_result("noise", 32'h06260060);
    expect_resp("noise", base, 32'h06260060);
    chk("noise_op_a", 64'(op_a), 64'h1234);
    chk("noise_op_b", 64'(op_b), 64'h5678);

    // Timeout after one operand byte
    base = tx_q.size();
    opv0 = opv_cnt;
    fe0  = fe_cnt;
    send_byte(8'hA5);
    send_byte(8'h01);
    repeat (45) tick();
    chk("to_busy_before", 64'(busy), 64'(1));
    chk("to_fe_before", 64'(fe_cnt - fe0), 64'(0));
    repeat (20) tick();
    chk("to_fe_pulses", 64'(fe_cnt - fe0), 64'(1));
    chk("to_busy_after", 64'(busy), 64'(0));
    chk("to_no_opv", 64'(opv_cnt - opv0), 64'(0));
    chk("to_no_tx", 64'(tx_q.size() - base), 64'(0));
    base = tx_q.size();
    send_frame(16'h0005, 16'h0006);
    give_result("after_to", 32'h0000001E);
    expect_resp("after_to", base, 32'h0000001E);

    // Backpressure with an injected sync byte during transmission
    base = tx_q.size();
    opv0 = opv_cnt;
    send_frame(16'h0007, 16'h0008);
    give_result("bp", 32'h00000038);
    n = 0;
    while (tx_q.size() < base + 1 && n < 100) begin
      tick();
      n++;
    end
    hold_ready = 1'b1;
    send_byte(8'hA5);
    send_byte(8'h00);
    repeat (200) tick();
    chk("bp_held_count", 64'(tx_q.size() - base), 64'(1));
    chk("bp_held_busy", 64'(busy), 64'(1));
    hold_ready = 1'b0;
    expect_resp("bp", base, 32'h00000038);
    repeat (10) tick();
    chk("bp_inject_ignored", 64'(busy), 64'(0));
    chk("bp_opv_pulses", 64'(opv_cnt - opv0), 64'(1));

    // Reset after the second response byte
    base = tx_q.size();
    send_frame(16'h0002, 16'h0003);
    give_result("mid", 32'h00000006);
    n = 0;
    while (tx_q.size() < base + 2 && n < 200) begin
      tick();
      n++;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_tx_start", 64'(tx_start), 64'(0));
    chk("mid_rst_tx_data", 64'(tx_data), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_op_a", 64'(op_a), 64'(0));
    chk("mid_rst_op_b", 64'(op_b), 64'(0));
    chk("mid_rst_op_valid", 64'(op_valid), 64'(0));
    repeat (60) tick();
    chk("mid_rst_no_more_tx", 64'(tx_q.size() - base), 64'(2));
    base = tx_q.size();
    send_frame(16'h0009, 16'h000A);
    give_result("post_rst", 32'h0000005A);
    expect_resp("post_rst", base, 32'h0000005A);

`ifdef UART_CMD_CHECKSUM_EN
    // Bad checksum: error byte only, no multiplier request
    base = tx_q.size();
    opv0 = opv_cnt;
    fe0  = fe_cnt;
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h03);
    send_byte(8'h00);
    send_byte(8'h04);
    send_byte(8'h00);
    n = 0;
    while (!(tx_q.size() >= base + 1 && !busy) && n < 200) begin
      tick();
      n++;
    end
    repeat (10) tick();
    chk("ck_fe_pulses", 64'(fe_cnt - fe0), 64'(1));
    chk("ck_no_opv", 64'(opv_cnt - opv0), 64'(0));
    chk("ck_tx_count", 64'(tx_q.size() - base), 64'(1));
    chk("ck_tx_byte", 64'((tx_q.size() > base) ? tx_q[base] : 8'hxx), 64'h00EE);
`endif

    chk("tx_protocol_violations", 64'(tx_viol), 64'(0));
    chk("opv_long_total", 64'(opv_long), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
